// File: rtl/spi_rx_ctrl.sv
// rtl/spi_rx_ctrl.sv - SPI receive sequencer: frame counting, RX FIFO, trailing CRC check
module spi_rx_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int AW         = 3
) (
  input  logic          clk_rx,
  input  logic          spi_rx_rstn,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    cfg_df,
  input  logic [12:0]   cfg_tnum_max,
  input  logic          cfg_crc_en,
  input  logic          word_vld,
  input  logic [31:0]   word_data,
  input  logic [31:0]   crc_calc,
  input  logic          fifo_rd_en,
  input  logic          err_clr,
  output logic [31:0]   fifo_rd_data,
  output logic          fifo_empty,
  output logic          fifo_full,
  output logic [AW:0]   fifo_level,
  output logic          busy,
  output logic          done,
  output logic [13:0]   frame_cnt,
  output logic          crc_err,
  output logic          ovr_err
);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_CRCW} state_t;

  state_t        state_q, state_d;
  logic [1:0]    df_q, df_d;
  logic [12:0]   tnum_q, tnum_d;
  logic          crc_en_q, crc_en_d;
  logic [31:0]   crc_q, crc_d;
  logic [13:0]   frame_cnt_q, frame_cnt_d;
  logic          done_q, done_d;
  logic          crc_err_q, crc_err_d;
  logic          ovr_err_q, ovr_err_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [31:0]   mem_q [FIFO_DEPTH];

  logic          push_req, crc_chk;
  logic          push, pop, crc_mismatch;
  logic [31:0]   mask, word_masked;

  function automatic logic [31:0] df_mask(input logic [1:0] df);
    case (df)
      2'b00:   df_mask = 32'h0000_00FF;
      2'b01:   df_mask = 32'h0000_FFFF;
      default: df_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

  assign mask        = df_mask(df_q);
  assign word_masked = word_data & mask;

  always_comb begin
    state_d     = state_q;
    df_d        = df_q;
    tnum_d      = tnum_q;
    crc_en_d    = crc_en_q;
    crc_d       = crc_q;
    frame_cnt_d = frame_cnt_q;
    done_d      = 1'b0;
    push_req    = 1'b0;
    crc_chk     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d     = S_RECV;
          df_d        = cfg_df;
          tnum_d      = cfg_tnum_max;
          crc_en_d    = cfg_crc_en;
          frame_cnt_d = '0;
        end
      end
      S_RECV: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (word_vld) begin
          push_req    = 1'b1;
          frame_cnt_d = frame_cnt_q + 14'd1;
          // frame_cnt_q still holds the count before this frame
          if (frame_cnt_q == {1'b0, tnum_q}) begin
            if (crc_en_q) begin
              crc_d   = crc_calc & mask;
              state_d = S_CRCW;
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
      S_CRCW: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (word_vld) begin
          crc_chk = 1'b1;
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A full FIFO still accepts a word when the host pops in the same cycle
  assign pop          = fifo_rd_en && !fifo_empty;
  assign push         = push_req && (!fifo_full || fifo_rd_en);
  assign crc_mismatch = crc_chk && (word_masked != crc_q);

  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d   = level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    crc_err_d = crc_mismatch ? 1'b1 : (err_clr ? 1'b0 : crc_err_q);
    ovr_err_d = (push_req && !push) ? 1'b1 : (err_clr ? 1'b0 : ovr_err_q);
  end

  always_ff @(posedge clk_rx or negedge spi_rx_rstn) begin
    if (!spi_rx_rstn) begin
      state_q     <= S_IDLE;
      df_q        <= '0;
      tnum_q      <= '0;
      crc_en_q    <= 1'b0;
      crc_q       <= '0;
      frame_cnt_q <= '0;
      done_q      <= 1'b0;
      crc_err_q   <= 1'b0;
      ovr_err_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      df_q        <= df_d;
      tnum_q      <= tnum_d;
      crc_en_q    <= crc_en_d;
      crc_q       <= crc_d;
      frame_cnt_q <= frame_cnt_d;
      done_q      <= done_d;
      crc_err_q   <= crc_err_d;
      ovr_err_q   <= ovr_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      if (push) mem_q[wr_ptr_q] <= word_masked;
    end
  end

  assign fifo_empty   = (level_q == '0);
  assign fifo_full    = (level_q == (AW+1)'(FIFO_DEPTH));
  assign fifo_level   = level_q;
  assign fifo_rd_data = fifo_empty ? 32'h0 : mem_q[rd_ptr_q];
  assign busy         = (state_q == S_RECV) || (state_q == S_CRCW);
  assign done         = done_q;
  assign frame_cnt    = frame_cnt_q;
  assign crc_err      = crc_err_q;
  assign ovr_err      = ovr_err_q;

endmodule
